// File: rtl/counter_seq_ctrl.sv
// Start/stop/pause sequencer for a WIDTH-bit up/down counter with one-shot or auto-reload.
// Optional tick prescaler enabled by defining COUNTER_SEQ_PRESCALE_EN.
module counter_seq_ctrl #(
  parameter int WIDTH = 3
`ifdef COUNTER_SEQ_PRESCALE_EN
  ,
  parameter int PRESC_W = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic               reload_mode,
`ifdef COUNTER_SEQ_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]   count,
  output logic [1:0]         state,
  output logic               busy,
  output logic               paused,
  output logic               tc,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic [WIDTH-1:0] term_s;
  logic             tick_s;

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;

  // Prescaler tick: one step every div_q+1 RUN cycles.
  always_comb begin
    tick_s = (presc_q == div_q);
  end
`else
  // Without a prescaler every RUN cycle is a tick.
  always_comb begin
    tick_s = 1'b1;
  end
`endif

  // Terminal value depends on the latched direction.
  always_comb begin
    if (dir_q) begin
      term_s = CNT_ZERO;
    end else begin
      term_s = CNT_ONES;
    end
  end

  // Next-state logic; priority stop > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_d   = load_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
    presc_d  = presc_q;
    div_d    = div_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (start) begin
          state_d  = ST_RUN;
          count_d  = load_val;
          load_d   = load_val;
          dir_d    = dir;
          reload_d = reload_mode;
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d  = {PRESC_W{1'b0}};
          div_d    = presc_div;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d = {PRESC_W{1'b0}};
`endif
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick_s) begin
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d = {PRESC_W{1'b0}};
`endif
          if (count_q != term_s) begin
            if (dir_q) begin
              count_d = count_q - CNT_ONE;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else if (reload_q) begin
            count_d = load_q;
            tc_d    = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d = presc_q + PRESC_W'(1);
`endif
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
`ifdef COUNTER_SEQ_PRESCALE_EN
          presc_d = {PRESC_W{1'b0}};
`endif
        end else if (!pause) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    paused_d = (state_d == ST_PAUSE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      load_q   <= CNT_ZERO;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_q  <= {PRESC_W{1'b0}};
      div_q    <= {PRESC_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      load_q   <= load_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_q  <= presc_d;
      div_q    <= div_d;
`endif
    end
  end

  assign count  = count_q;
  assign state  = state_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign tc     = tc_q;
  assign done   = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl (default build): expected outputs are queued
// per cycle as stimulus is applied and checked one edge later.
module tb_counter_seq_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [2:0] cnt;
    logic [1:0] st;
    logic       tcx;
    logic       dnx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       dir = 1'b0;
  logic       reload_mode = 1'b0;
  logic [2:0] count;
  logic [1:0] state;
  logic       busy, paused, tc, done;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  counter_seq_ctrl #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .load_val(load_val), .dir(dir), .reload_mode(reload_mode),
    .count(count), .state(state), .busy(busy), .paused(paused),
    .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then check.
  task automatic cyc(input string tag, input logic s_i, input logic p_i, input logic a_i,
                     input logic [2:0] lv, input logic d_i, input logic rm,
                     input logic [2:0] e_cnt, input logic [1:0] e_st,
                     input logic e_tc, input logic e_done);
    exp_t e;
    start = s_i; stop = p_i; pause = a_i;
    load_val = lv; dir = d_i; reload_mode = rm;
    e.cnt = e_cnt; e.st = e_st; e.tcx = e_tc; e.dnx = e_done;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".count"},  count, e.cnt);
    chk({tag, ".state"},  {1'b0, state}, {1'b0, e.st});
    chk({tag, ".busy"},   {2'b00, busy},   {2'b00, (e.st == S_RUN) || (e.st == S_PAUSE)});
    chk({tag, ".paused"}, {2'b00, paused}, {2'b00, (e.st == S_PAUSE)});
    chk({tag, ".tc"},     {2'b00, tc},     {2'b00, e.tcx});
    chk({tag, ".done"},   {2'b00, done},   {2'b00, e.dnx});
  endtask

  initial begin
    // reset held two cycles
    rst = 1'b1;
    cyc("rst0", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);
    cyc("rst1", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("idle", 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);

    // up one-shot from 5
    cyc("up_e0", 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 3'd5, S_RUN,  1'b0, 1'b0);
    cyc("up_e1", 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 3'd6, S_RUN,  1'b0, 1'b0);
    cyc("up_e2", 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 3'd7, S_RUN,  1'b0, 1'b0);
    cyc("up_e3", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, S_DONE, 1'b0, 1'b1);
    cyc("up_e4", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, S_DONE, 1'b0, 1'b0);

    // down auto-reload from 2, restarted from DONE; start/config changes mid-run ignored
    cyc("dn_s",  1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2, S_RUN, 1'b0, 1'b0);
    cyc("dn_1",  1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd1, S_RUN, 1'b0, 1'b0);
    cyc("dn_0",  1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0, S_RUN, 1'b0, 1'b0);
    cyc("dn_r1", 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd2, S_RUN, 1'b1, 1'b0);
    cyc("dn_1b", 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd1, S_RUN, 1'b0, 1'b0);
    cyc("dn_0b", 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0, S_RUN, 1'b0, 1'b0);
    cyc("dn_r2", 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd2, S_RUN, 1'b1, 1'b0);
    cyc("dn_stp",1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);

    // pause at 3 for four cycles, resume
    cyc("pz_s",  1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1, S_RUN,   1'b0, 1'b0);
    cyc("pz_2",  1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd2, S_RUN,   1'b0, 1'b0);
    cyc("pz_3",  1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd3, S_RUN,   1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("pz_hold", 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd3, S_PAUSE, 1'b0, 1'b0);
    cyc("pz_rel",1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd3, S_RUN,   1'b0, 1'b0);
    cyc("pz_4",  1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd4, S_RUN,   1'b0, 1'b0);

    // start in RUN ignored, then stop+start together: stop wins
    cyc("ign_st",1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, S_RUN,  1'b0, 1'b0);
    cyc("ss",    1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);
    cyc("ss_idl",1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);

    // auto-reload with load_val == TERM: tc every tick, count constant
    cyc("t7_s",  1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 3'd7, S_RUN,  1'b0, 1'b0);
    cyc("t7_a",  1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 3'd7, S_RUN,  1'b1, 1'b0);
    cyc("t7_b",  1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 3'd7, S_RUN,  1'b1, 1'b0);
    cyc("t7_stp",1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 3'd0, S_IDLE, 1'b0, 1'b0);

    // one-shot down with load_val == TERM: first tick terminates
    cyc("t0_s",  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, S_RUN,  1'b0, 1'b0);
    cyc("t0_d",  1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, S_DONE, 1'b0, 1'b1);
    cyc("t0_h",  1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, S_DONE, 1'b0, 1'b0);
    cyc("dn_stp2",1'b0,1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, S_IDLE, 1'b0, 1'b0);

    // stop from PAUSE, then reset overrides a running count
    cyc("sp_s",  1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd3, S_RUN,   1'b0, 1'b0);
    cyc("sp_p",  1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd3, S_PAUSE, 1'b0, 1'b0);
    cyc("sp_st", 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, S_IDLE,  1'b0, 1'b0);
    cyc("rr_s",  1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd4, S_RUN,   1'b0, 1'b0);
    rst = 1'b1;
    cyc("rr_rst",1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, S_IDLE,  1'b0, 1'b0);
    rst = 1'b0;
    cyc("rr_idl",1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, S_IDLE,  1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
